// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO slave: register word addresses,
// edge-type selectors and the widest supported PIO vector.
package pio_pkg;

  // Widest PIO vector the block is built for.
  localparam int PIO_MAX_WIDTH = 32;

  // Word addresses of the slave register map. Addresses 6 and 7 are reserved.
  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGE    = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5
  } pio_addr_e;

  // Which input transition sets an edge-capture bit.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage : pio_pkg

// File: rtl/pio_edge_sync.sv
// Input conditioning for the PIO: a SYNC_STAGES-deep synchroniser on every
// pin, a previous-value register behind it, and a per-bit edge detector
// selected by EDGE_TYPE. Edge detection ignores pin direction on purpose so
// that outputs looped back to the pins can also raise events.
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  // Elaboration-time guard on the supported parameter ranges.
  if (WIDTH < 1 || WIDTH > PIO_MAX_WIDTH) begin : g_bad_width
    $error("pio_edge_sync: WIDTH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("pio_edge_sync: SYNC_STAGES out of range");
  end

  // Stage 0 samples the raw pins; the last stage is the synchronised value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  prev_d;

  // Next-state of the synchroniser shift chain and the previous-value flop.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop writes it, so no path through the block can leave it unassigned
    // and infer a latch.
    sync_d    = sync_q;
    sync_d[0] = pin_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and previous-value registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: clocked state is updated with non-blocking assignments so every
      // stage samples the value its predecessor held before this edge; a
      // blocking shift would collapse the chain into a single flop.
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Edge detection between the synchronised value and its one-cycle history.
  always_comb begin
    edge_pulse = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_pulse =  sync_in & ~prev_q;
      EDGE_FALLING: edge_pulse = ~sync_in &  prev_q;
      default:      edge_pulse =  sync_in ^  prev_q;
    endcase
  end

endmodule : pio_edge_sync

// File: rtl/avalon_pio_multi.sv
// Parametrised Avalon-MM PIO slave: WIDTH bidirectional bits with per-bit
// direction, synchronised inputs, sticky edge capture and a maskable level
// interrupt. Read latency is fixed at one cycle.
//
// Build option: define PIO_OUTSETCLR_EN to enable the atomic OUTSET (4) and
// OUTCLR (5) registers; without it those addresses behave as reserved and no
// set/clear logic is built.
module avalon_pio_multi
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  // Bus strobes.
  logic wr_en;
  logic rd_en;

  assign wr_en = chipselect && !write_n;
  assign rd_en = chipselect && !read_n;

  // Register state.
  logic [WIDTH-1:0] out_port_q,     out_port_d;
  logic [WIDTH-1:0] oe_q,           oe_d;
  logic [WIDTH-1:0] irq_mask_q,     irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] readdata_q,     readdata_d;
  logic             irq_q,          irq_d;

  // Write-1-to-clear mask for edge_capture from the current bus write.
  logic [WIDTH-1:0] edge_clr;

  // Conditioned pin inputs.
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;

  pio_edge_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .pin_in     (pin_in),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  // Register writes, edge capture and interrupt next-state.
  always_comb begin
    out_port_d = out_port_q;
    oe_d       = oe_q;
    irq_mask_d = irq_mask_q;
    edge_clr   = '0;

    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_port_d = writedata;
        ADDR_DIR:     oe_d       = writedata;
        ADDR_IRQMASK: irq_mask_d = writedata;
        ADDR_EDGE:    edge_clr   = writedata;
`ifdef PIO_OUTSETCLR_EN
        ADDR_OUTSET:  out_port_d = out_port_q | writedata;
        ADDR_OUTCLR:  out_port_d = out_port_q & ~writedata;
`endif
        default:      ;
      endcase
    end

    // A new edge wins over a same-cycle clear so no event is ever lost.
    edge_capture_d = (edge_capture_q & ~edge_clr) | edge_pulse;

    // The interrupt follows the registered capture and mask, one cycle behind.
    irq_d = |(edge_capture_q & irq_mask_q);
  end

  // Read mux: samples the pre-write register contents, holds when idle.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        ADDR_DATA:    readdata_d = (out_port_q & oe_q) | (sync_in & ~oe_q);
        ADDR_DIR:     readdata_d = oe_q;
        ADDR_IRQMASK: readdata_d = irq_mask_q;
        ADDR_EDGE:    readdata_d = edge_capture_q;
        default:      readdata_d = '0;
      endcase
    end
  end

  // All slave state, cleared asynchronously; a read in flight is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every flop here has a defined reset value, including readdata,
      // because software and the interconnect may observe any of them right
      // after reset; nothing in this block is a RAM that could skip reset.
      out_port_q     <= RESET_VALUE;
      oe_q           <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      out_port_q     <= out_port_d;
      oe_q           <= oe_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_port_q;
  assign oe       = oe_q;
  assign irq      = irq_q;

endmodule : avalon_pio_multi

// File: tb/tb_avalon_pio_multi.sv
// Bench for avalon_pio_multi: directed scenarios followed by random bus and
// pin traffic, all compared cycle by cycle against a register-level model.
module tb_avalon_pio_multi;
  import pio_pkg::*;

  localparam int           W  = 8;
  localparam int           S  = 2;
  localparam int           ET = 0;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   address;
  logic         chipselect;
  logic         read_n;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] readdata;
  logic [W-1:0] pin_in;
  logic [W-1:0] out_port;
  logic [W-1:0] oe;
  logic         irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avalon_pio_multi #(
    .WIDTH       (W),
    .RESET_VALUE (RV),
    .EDGE_TYPE   (ET),
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pin_in     (pin_in),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  // Reference model: architectural registers plus a history of pin samples,
  // newest first. The synchronised pin is the sample taken S edges back and
  // the previous value is the one before that.
  logic [W-1:0] m_out, m_oe, m_mask, m_cap, m_rd;
  logic         m_irq;
  logic [W-1:0] ph[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out  = RV;
    m_oe   = '0;
    m_mask = '0;
    m_cap  = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
    ph.delete();
    for (int i = 0; i <= S; i++) ph.push_back('0);
  endtask

  function automatic logic [W-1:0] m_read(input logic [2:0] a);
    logic [W-1:0] pins;
    pins = ph[S-1];
    case (a)
      3'd0:    return (m_out & m_oe) | (pins & ~m_oe);
      3'd1:    return m_oe;
      3'd2:    return m_mask;
      3'd3:    return m_cap;
      default: return '0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".out_port"}, 32'(out_port), 32'(m_out));
    check({tag, ".oe"},       32'(oe),       32'(m_oe));
    check({tag, ".irq"},      32'(irq),      32'(m_irq));
    check({tag, ".readdata"}, 32'(readdata), 32'(m_rd));
  endtask

  // One clock: predict the post-edge state from the current inputs, clock,
  // then compare every output 1 ns after the edge.
  task automatic step(input string tag);
    logic [W-1:0] cur, prv, ev, clr, n_out, n_oe, n_mask, n_cap, n_rd, p;
    logic         n_irq, wr, rd;
    cur    = ph[S-1];
    prv    = ph[S];
    wr     = chipselect && !write_n;
    rd     = chipselect && !read_n;
    p      = pin_in;
    n_out  = m_out;
    n_oe   = m_oe;
    n_mask = m_mask;
    clr    = '0;
    n_rd   = rd ? m_read(address) : m_rd;
    if (wr) begin
      case (address)
        3'd0: n_out  = writedata;
        3'd1: n_oe   = writedata;
        3'd2: n_mask = writedata;
        3'd3: clr    = writedata;
`ifdef PIO_OUTSETCLR_EN
        3'd4: n_out  = m_out | writedata;
        3'd5: n_out  = m_out & ~writedata;
`endif
        default: ;
      endcase
    end
    if (ET == 0)      ev = cur & ~prv;
    else if (ET == 1) ev = ~cur & prv;
    else              ev = cur ^ prv;
    n_cap = (m_cap & ~clr) | ev;
    n_irq = |(m_cap & m_mask);
    @(posedge clk);
    #1;
    ph.push_front(p);
    void'(ph.pop_back());
    m_out  = n_out;
    m_oe   = n_oe;
    m_mask = n_mask;
    m_cap  = n_cap;
    m_rd   = n_rd;
    m_irq  = n_irq;
    check_all(tag);
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [W-1:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step("wr");
    idle();
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [W-1:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    step("rd");
    d = readdata;
    idle();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step("idle");
  endtask

  initial begin
    logic [W-1:0] rdv;
    logic [W-1:0] exp_out;

    // Reset and register map defaults.
    reset_n = 1'b0;
    pin_in  = '0;
    idle();
    model_reset();
    #2;
    check("rst.out_port", 32'(out_port), 32'(RV));
    check("rst.oe",       32'(oe),       32'h0);
    check("rst.irq",      32'(irq),      32'h0);
    check("rst.readdata", 32'(readdata), 32'h0);
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), rdv);
      check($sformatf("reset_read%0d", a), 32'(rdv), 32'h0);
    end

    // Mixed direction DATA read.
    bus_wr(3'd1, 8'hF0);
    bus_wr(3'd0, 8'hA5);
    pin_in = 8'h0C;
    wait_cycles(S + 1);
    bus_rd(3'd0, rdv);
    check("mixed_data_read", 32'(rdv), 32'hAC);
    check("mixed_out_port",  32'(out_port), 32'hA5);
    check("mixed_oe",        32'(oe), 32'hF0);

    // Rising edge on bit 0 through capture and interrupt.
    bus_wr(3'd3, 8'hFF);
    bus_wr(3'd2, 8'h01);
    pin_in = 8'h0D;
    wait_cycles(S + 1);
    check("irq_before_latency", 32'(irq), 32'h0);
    step("irq_rise");
    check("irq_after_capture", 32'(irq), 32'h1);
    bus_rd(3'd3, rdv);
    check("edge_read", 32'(rdv), 32'h01);
    bus_wr(3'd3, 8'h01);
    check("irq_same_cycle_as_clear", 32'(irq), 32'h1);
    step("irq_fall");
    check("irq_after_clear", 32'(irq), 32'h0);

    // Clear landing on the same edge as a fresh capture.
    pin_in = 8'h0C;
    wait_cycles(S + 2);
    pin_in = 8'h0D;
    wait_cycles(S + 2);
    check("irq_rearmed", 32'(irq), 32'h1);
    pin_in = 8'h0C;
    wait_cycles(S + 1);
    pin_in = 8'h0D;
    wait_cycles(S);
    bus_wr(3'd3, 8'h01);
    check("irq_held_on_clear_race", 32'(irq), 32'h1);
    step("race_next");
    check("irq_still_set", 32'(irq), 32'h1);
    bus_rd(3'd3, rdv);
    check("edge_kept_on_race", 32'(rdv), 32'h01);

    // Atomic set/clear (or reserved behaviour when not built in).
    bus_wr(3'd0, 8'h0F);
    bus_wr(3'd4, 8'h30);
`ifdef PIO_OUTSETCLR_EN
    exp_out = 8'h3F;
`else
    exp_out = 8'h0F;
`endif
    check("outset", 32'(out_port), 32'(exp_out));
    bus_wr(3'd5, 8'h03);
`ifdef PIO_OUTSETCLR_EN
    exp_out = 8'h3C;
`else
    exp_out = 8'h0F;
`endif
    check("outclr", 32'(out_port), 32'(exp_out));
    bus_rd(3'd4, rdv);
    check("outset_reads_zero", 32'(rdv), 32'h0);
    bus_wr(3'd6, 8'hFF);
    bus_rd(3'd6, rdv);
    check("reserved_reads_zero", 32'(rdv), 32'h0);

    // Asynchronous reset in the middle of a read.
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd3, 8'hFF);
    pin_in = 8'h00;
    wait_cycles(S + 2);
    bus_wr(3'd2, 8'hFF);
    pin_in = 8'hFF;
    wait_cycles(S + 3);
    bus_wr(3'd0, 8'h55);
    bus_rd(3'd3, rdv);
    check("cap_all_set", 32'(rdv), 32'hFF);
    check("irq_pre_reset", 32'(irq), 32'h1);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset.out_port", 32'(out_port), 32'(RV));
    check("mid_reset.oe",       32'(oe),       32'h0);
    check("mid_reset.irq",      32'(irq),      32'h0);
    check("mid_reset.readdata", 32'(readdata), 32'h0);
    idle();
    pin_in = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int op;
      op         = int'($urandom_range(0, 2));
      chipselect = ($urandom_range(0, 7) != 0);
      read_n     = (op != 1);
      write_n    = (op != 2);
      address    = 3'($urandom_range(0, 7));
      writedata  = W'($urandom);
      if ($urandom_range(0, 3) == 0) pin_in = W'($urandom);
      step("rand");
    end
    idle();
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_avalon_pio_multi

// File: doc/avalon_pio_multi.md
Name: avalon_pio_multi

Overview:
- Parametrised Avalon-MM PIO slave; successor of the single-bit output-enable PIO used for LCD/I2C control lines.
- Provides WIDTH bidirectional bits with per-bit direction control, input synchronisation, edge capture and a maskable interrupt.
- Sits on the Nios system interconnect between the CPU data master and board-level GPIO, LCD and I2C pins.

Parameters:
- WIDTH, 8: number of PIO bits, 1..32.
- RESET_VALUE, 0: reset value of the output data register, WIDTH bits.
- EDGE_TYPE, 0: edge that sets capture bits; 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  3  word address
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  WIDTH  write data
- readdata  out  WIDTH  read data, registered
- pin_in  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  per-bit output enable (the direction register)
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk. All state is held in registers.
- Reset values: out_port=RESET_VALUE, oe=0, irq_mask=0, edge_capture=0, readdata=0, irq=0, all synchroniser and previous-value flops=0.
- Address map:
  - 0 DATA: write loads out_port. Read returns, per bit, out_port where oe=1, else the synchronised pin.
  - 1 DIR: read/write oe; 1 = output.
  - 2 IRQMASK: read/write.
  - 3 EDGE: read edge_capture; write-1-to-clear per bit.
  - 4 OUTSET: write-1 sets out_port bits; reads 0.
  - 5 OUTCLR: write-1 clears out_port bits; reads 0.
  - 6-7: reserved; writes ignored, reads 0.
- Write condition: chipselect && !write_n; register updates on the same clk edge.
- Read condition: chipselect && !read_n.
  - readdata is registered; fixed read latency of 1 cycle.
  - readdata holds its last value when no read is in progress.
  - Simultaneous read and write are not issued by the fabric. If they occur, the write takes effect and readdata returns the pre-write value.
- Input path: pin_in passes through SYNC_STAGES flops to form sync_in; a further flop holds prev_in.
  - Rising edge: sync_in & ~prev_in.
  - Falling edge: ~sync_in & prev_in.
  - Any edge: the XOR of the two.
  - Edge detection runs on every bit regardless of oe.
- Latency: a pin transition is visible in a DATA read and sets edge_capture SYNC_STAGES+1 cycles later.
- edge_capture bit:
  - Set on a detected edge, sticky until cleared.
  - Set has priority over a same-cycle write-1 clear, so no edge is lost.
- irq: registered as |(edge_capture & irq_mask); asserts one cycle after a capture bit or mask bit becomes active. Clearing all active bits deasserts irq one cycle after the write.
- Bit-width rules:
  - All registers are exactly WIDTH bits.
  - Unused writedata bits do not exist.
  - Reserved addresses ignore writedata entirely.
- Reset mid-operation: all state returns to reset values immediately. A read in flight is dropped and readdata=0.

Optional Feature:
- Macro: PIO_OUTSETCLR_EN.
- Defined: addresses 4/5 behave as above, giving atomic bit set/clear without read-modify-write.
- Undefined: addresses 4/5 are treated as reserved (writes ignored, reads 0). No set/clear logic is synthesised.

Decomposition:
- Shared package pio_pkg holds:
  - Address constants ADDR_DATA..ADDR_OUTCLR.
  - EDGE_RISING / EDGE_FALLING / EDGE_ANY constants.
  - The maximum-WIDTH constant (32).
- One sub-module, pio_edge_sync: per-vector synchroniser plus previous-value register plus edge detect. Parameters WIDTH, SYNC_STAGES, EDGE_TYPE; outputs sync_in and edge_pulse.

Test Plan:
- Reset, then read addresses 0-7 with pin_in=0 -> all reads 0, and out_port=RESET_VALUE, oe=0, irq=0.
- Write DIR=0xF0, write DATA=0xA5, pin_in=0x0C -> out_port=0xA5, oe=0xF0, DATA read=0xAC one cycle after the strobe.
- EDGE_TYPE=0, IRQMASK=0x01, pin_in bit0 0->1 -> EDGE read=0x01 at SYNC_STAGES+1 cycles, irq=1 one cycle later; write EDGE=0x01 -> irq=0 next cycle.
- Write EDGE=0x01 in the same cycle as a new rising edge on bit0 -> edge_capture bit0 stays 1 and irq stays 1.
- PIO_OUTSETCLR_EN defined, DATA=0x0F, write OUTSET=0x30, then OUTCLR=0x03 -> out_port=0x3F, then 0x3C. Macro undefined -> out_port stays 0x0F.
- Assert reset_n low mid-read with edge_capture=0xFF, out_port=0x55 -> all outputs return to reset values immediately with no clk edge required.
